// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key map for the hex keypad entry block
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} kp_state_t;

    localparam int NUM_DIGITS = 8;

    // Indexed [column][row]; rows read 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'hE},
        '{4'h2, 4'h5, 4'h8, 4'h0},
        '{4'h3, 4'h6, 4'h9, 4'hF},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with a configurable reset value
module sync_2ff #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/keypad_hex_entry.sv
// rtl/keypad_hex_entry.sv - 4x4 keypad scanner, debouncer and 8-digit hex entry buffer
import keypad_pkg::*;

module keypad_hex_entry #(
    parameter int DWELL_CYCLES = 50_000,
    parameter int DEB_CYCLES   = 500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_n,
    input  logic        clr,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] digits,
    output logic [3:0]  digit_cnt
);

    localparam int CNT_MAX = (DWELL_CYCLES > DEB_CYCLES) ? DWELL_CYCLES : DEB_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);

    kp_state_t      r_state;
    kp_state_t      w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_col;
    logic [1:0]     r_row;
    logic [3:0]     r_col_n;
    logic [3:0]     r_key_code;
    logic           r_key_valid;
    logic           r_key_held;
    logic [31:0]    r_digits;
    logic [3:0]     r_digit_cnt;

    logic [3:0]     w_row_s;
    logic [1:0]     w_first_low;
    logic [1:0]     w_col_nxt;
    logic           w_key_low;
    logic           w_cnt_clr;
    logic           w_cnt_inc;
    logic           w_latch;
    logic           w_accept;
    logic           w_release;

    sync_2ff #(.W(4), .RST_VAL(4'hF)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (row_n),
        .o_q   (w_row_s)
    );

    assign w_key_low   = ~w_row_s[r_row];
    assign w_first_low = !w_row_s[0] ? 2'd0 :
                         !w_row_s[1] ? 2'd1 :
                         !w_row_s[2] ? 2'd2 : 2'd3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= SCAN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_latch     = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            SCAN: begin
                // Rows only looked at on the final dwell cycle so the column has settled
                if (r_cnt == DWELL_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (w_row_s != 4'hF) begin
                        w_latch     = 1'b1;
                        w_state_nxt = DEB_PRESS;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DEB_PRESS: begin
                if (!w_key_low) begin
                    w_cnt_clr   = 1'b1;
                    w_col_nxt   = r_col + 2'd1;
                    w_state_nxt = SCAN;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_accept    = 1'b1;
                    w_state_nxt = HELD;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            HELD: begin
                if (!w_key_low) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = DEB_REL;
                end
            end
            DEB_REL: begin
                if (w_key_low) begin
                    w_cnt_clr = 1'b1;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_release   = 1'b1;
                    w_col_nxt   = 2'd0;
                    w_state_nxt = SCAN;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_cnt <= '0;
        else if (w_cnt_clr) r_cnt <= '0;
        else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col       <= 2'd0;
            r_col_n     <= 4'b1110;
            r_row       <= 2'd0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_col       <= w_col_nxt;
            r_col_n     <= ~(4'b0001 << w_col_nxt);
            r_key_valid <= w_accept;
            if (w_latch)
                r_row <= w_first_low;
            if (w_accept) begin
                r_key_code <= KEYMAP[r_col][r_row];
                r_key_held <= 1'b1;
            end
            if (w_release)
                r_key_held <= 1'b0;
        end
    end

    // clr takes priority so a key landing on the same cycle is dropped from the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits    <= 32'h0;
            r_digit_cnt <= 4'd0;
        end else if (clr) begin
            r_digits    <= 32'h0;
            r_digit_cnt <= 4'd0;
        end else if (r_key_valid) begin
            r_digits <= {r_digits[27:0], r_key_code};
            if (r_digit_cnt != 4'(NUM_DIGITS))
                r_digit_cnt <= r_digit_cnt + 4'd1;
        end
    end

    assign col_n     = r_col_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign digits    = r_digits;
    assign digit_cnt = r_digit_cnt;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb/tb_keypad_hex_entry.sv - directed self-checking bench for keypad_hex_entry
module tb_keypad_hex_entry;

    localparam int DW = 4;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] digits;
    logic [3:0]  digit_cnt;

    logic        pressed = 1'b0;
    int          pc = 0;
    int          pr = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_valid = 0;

    assign row_n = (pressed && !col_n[pc]) ? ~(4'b0001 << pr) : 4'hF;

    keypad_hex_entry #(.DWELL_CYCLES(DW), .DEB_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .clr       (clr),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digits    (digits),
        .digit_cnt (digit_cnt)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (key_valid) n_valid++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] target);
        int k;
        k = 0;
        while (col_n == target && k < 64) begin @(negedge clk); k++; end
        while (col_n != target && k < 128) begin @(negedge clk); k++; end
        check("wait_col", col_n, target);
    endtask

    task automatic wait_release();
        int k;
        k = 0;
        while (key_held && k < 60) begin @(negedge clk); k++; end
        check("held_fall", key_held, 1'b0);
        tick(1);
    endtask

    task automatic press_key(input int c, input int r, input int hold, input bit do_clr);
        logic [3:0] t;
        t = ~(4'b0001 << c);
        wait_col(t);
        pc = c;
        pr = r;
        pressed = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            clr = do_clr && key_valid;
        end
        clr = 1'b0;
        pressed = 1'b0;
        wait_release();
    endtask

    int fill_c [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int fill_r [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

    initial begin
        int t;
        int v0;
        logic [3:0] exp_col;

        @(negedge clk);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_digits", digits, 32'h0);
        check("rst_digit_cnt", digit_cnt, 4'd0);
        reset = 1'b0;

        for (int j = 0; j <= 16; j++) begin
            exp_col = ~(4'b0001 << ((j / DW) % 4));
            check("idle_col", col_n, exp_col);
            @(negedge clk);
        end
        check("idle_no_valid", n_valid, 0);
        check("idle_digits", digits, 32'h0);

        // Clean press of '8' at column 1 row 2, held 30 cycles
        v0 = n_valid;
        wait_col(4'b1101);
        pc = 1; pr = 2; pressed = 1'b1;
        t = 0;
        while (!key_valid && t < 40) begin @(negedge clk); t++; end
        check("press_latency", t, 12);
        check("press_code", key_code, 4'h8);
        tick(30 - t);
        check("held_at_release", key_held, 1'b1);
        pressed = 1'b0;
        t = 0;
        while (key_held && t < 40) begin @(negedge clk); t++; end
        check("release_latency", t, 11);
        check("press_pulses", n_valid - v0, 1);
        check("press_digits", digits, 32'h8);
        check("press_cnt", digit_cnt, 4'd1);
        tick(1);

        // '5' with a bounce while debouncing, then a bouncy release
        v0 = n_valid;
        wait_col(4'b1101);
        pc = 1; pr = 1; pressed = 1'b1;
        tick(7);
        pressed = 1'b0;
        tick(2);
        check("bounce_no_early", n_valid - v0, 0);
        pressed = 1'b1;
        t = 0;
        while (!key_valid && t < 60) begin @(negedge clk); t++; end
        check("bounce_latency", t, 25);
        check("bounce_code", key_code, 4'h5);
        tick(10);
        pressed = 1'b0; tick(3);
        pressed = 1'b1; tick(2);
        pressed = 1'b0; tick(3);
        pressed = 1'b1; tick(2);
        pressed = 1'b0;
        check("bounce_still_held", key_held, 1'b1);
        wait_release();
        check("bounce_pulses", n_valid - v0, 1);
        check("bounce_digits", digits, 32'h85);
        check("bounce_cnt", digit_cnt, 4'd2);

        // 5-cycle glitch on column 2: column held 8 cycles then scanning moves on
        v0 = n_valid;
        wait_col(4'b1011);
        pc = 2; pr = 2; pressed = 1'b1;
        t = 0;
        while (col_n == 4'b1011 && t < 40) begin
            if (t == 5) pressed = 1'b0;
            t++;
            @(negedge clk);
        end
        pressed = 1'b0;
        check("glitch_dwell", t, 8);
        check("glitch_next_col", col_n, 4'b0111);
        tick(20);
        check("glitch_no_valid", n_valid - v0, 0);

        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_digits", digits, 32'h0);
        check("clr_cnt", digit_cnt, 4'd0);

        for (int i = 0; i < 9; i++) begin
            press_key(fill_c[i], fill_r[i], 20, 1'b0);
            if (i == 7) begin
                check("fill8_digits", digits, 32'h1234_5678);
                check("fill8_cnt", digit_cnt, 4'd8);
            end
        end
        check("fill9_digits", digits, 32'h2345_6789);
        check("fill9_cnt", digit_cnt, 4'd8);

        v0 = n_valid;
        press_key(3, 0, 20, 1'b1);
        check("clrkey_pulses", n_valid - v0, 1);
        check("clrkey_digits", digits, 32'h0);
        check("clrkey_cnt", digit_cnt, 4'd0);
        check("clrkey_code", key_code, 4'hA);

        press_key(0, 2, 20, 1'b0);
        check("pre_rst_digits", digits, 32'h7);
        check("pre_rst_cnt", digit_cnt, 4'd1);

        // Reset while '0' is being debounced
        v0 = n_valid;
        wait_col(4'b1101);
        pc = 1; pr = 3; pressed = 1'b1;
        tick(6);
        check("mid_no_valid", n_valid - v0, 0);
        reset = 1'b1;
        #1;
        check("mrst_col_n", col_n, 4'b1110);
        check("mrst_key_code", key_code, 4'h0);
        check("mrst_key_valid", key_valid, 1'b0);
        check("mrst_key_held", key_held, 1'b0);
        check("mrst_digits", digits, 32'h0);
        check("mrst_cnt", digit_cnt, 4'd0);
        pressed = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick(40);
        check("mrst_no_valid", n_valid - v0, 0);
        check("mrst_code_after", key_code, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
